// File: rtl/spi_reg_bank_if.sv
// Byte-level handshake between the SPI slave shifter and the register bank.
// master: the SPI slave side (delivers received bytes, loads tx bytes).
// slave:  the register bank (consumes rx bytes, supplies tx bytes).
interface spi_reg_bank_if;
  logic       spi_cs;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;

  modport master (
    output spi_cs,
    output rx_dv,
    output rx_byte,
    input  tx_dv,
    input  tx_byte
  );

  modport slave (
    input  spi_cs,
    input  rx_dv,
    input  rx_byte,
    output tx_dv,
    output tx_byte
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-accessible configuration register bank.
// Decodes a command byte (bit7 = write, bits[6:0] = address) followed by data
// bytes, returns read data through tx_dv/tx_byte and exposes all registers as
// a flat vector.
// Optional feature: define SPI_REGBANK_BURST_EN to keep accepting data bytes
// at auto-incrementing addresses; otherwise only the first data byte of a
// frame is used.
//
// state  | meaning
// IDLE   | waiting for chip-select to fall
// CMD    | expecting the command/address byte
// DATA   | expecting a data (write) or dummy (read) byte
// IGNORE | single access done, remaining bytes of the frame are dropped
module spi_reg_bank #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] IDLE_BYTE = 8'hA5,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_reg_bank_if.slave         bus,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  addr_err
);

`ifdef SPI_REGBANK_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [7:0] NUM_W = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

  state_t     state_q, state_n;
  logic       cs_m, cs_s, cs_d;
  logic       frame_start, frame_end, rx_ok;
  logic       op_q;
  logic [6:0] addr_q;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] reg_q [NUM_REGS];

  logic       tx_dv_n, tx_load, wr_en, err_n, lat_cmd, addr_inc;
  logic [7:0] tx_byte_n;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NUM_W;
  endfunction

  // Two-flop chip-select synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_m <= 1'b1;
      cs_s <= 1'b1;
      cs_d <= 1'b1;
    end else begin
      cs_m <= bus.spi_cs;
      cs_s <= cs_m;
      cs_d <= cs_s;
    end
  end

  assign frame_start = cs_d & ~cs_s;
  assign frame_end   = ~cs_d & cs_s;
  assign rx_ok       = bus.rx_dv & ~cs_s;

  // Read address: the incoming command address, or the next burst address.
  assign rd_addr = (state_q == CMD) ? bus.rx_byte[6:0] : addr_q + 7'd1;

  // Read mux; out-of-range addresses read back as zero.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i)) rd_data = reg_q[i];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic; frame end overrides everything.
  always_comb begin
    state_n = state_q;
    if (frame_end) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (frame_start) state_n = CMD;
        CMD:     if (rx_ok) state_n = DATA;
        DATA:    if (rx_ok) state_n = BURST ? DATA : IGNORE;
        default: state_n = state_q;
      endcase
    end
  end

  // Output decode: next values for the registered outputs and datapath enables.
  always_comb begin
    tx_dv_n   = 1'b0;
    tx_load   = 1'b0;
    tx_byte_n = IDLE_BYTE;
    wr_en     = 1'b0;
    err_n     = 1'b0;
    lat_cmd   = 1'b0;
    addr_inc  = 1'b0;
    if (frame_end) begin
      tx_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            tx_dv_n = 1'b1;
            tx_load = 1'b1;
          end
        end
        CMD: begin
          if (rx_ok) begin
            lat_cmd = 1'b1;
            tx_dv_n = 1'b1;
            tx_load = 1'b1;
            if (!bus.rx_byte[7]) tx_byte_n = rd_data;
          end
        end
        DATA: begin
          if (rx_ok) begin
            wr_en    = op_q & in_range(addr_q);
            err_n    = ~in_range(addr_q);
            tx_dv_n  = 1'b1;
            tx_load  = 1'b1;
            addr_inc = BURST;
            if (BURST && !op_q) tx_byte_n = rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered handshake outputs and the latched command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.tx_dv   <= 1'b0;
      bus.tx_byte <= IDLE_BYTE;
      wr_strobe   <= 1'b0;
      wr_addr     <= 7'd0;
      addr_err    <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= 7'd0;
    end else begin
      bus.tx_dv <= tx_dv_n;
      if (tx_load) bus.tx_byte <= tx_byte_n;
      wr_strobe <= wr_en;
      if (wr_en) wr_addr <= addr_q;
      addr_err <= err_n;
      if (lat_cmd) begin
        op_q   <= bus.rx_byte[7];
        addr_q <= bus.rx_byte[6:0];
      end else if (addr_inc) begin
        addr_q <= addr_q + 7'd1;
      end
    end
  end

  // Register array; a write lands on the same edge that accepts the data byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= RESET_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_q == 7'(i)) reg_q[i] <= bus.rx_byte;
      end
    end
  end

  // Flatten for the rest of the chip.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[8*g +: 8] = reg_q[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with a timing-aware scoreboard: each
// stimulus step queues the tx/write/error events it should cause, stamped
// with the cycle they must appear in; a negedge monitor pops and compares.
module tb_spi_reg_bank;

`ifdef SPI_REGBANK_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int         NR   = 16;
  localparam logic [7:0] IDLE = 8'hA5;

  typedef struct { int cyc; logic [7:0] data; } tx_exp_t;
  typedef struct { int cyc; logic [6:0] addr; logic [7:0] data; } wr_exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR*8-1:0] regs;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic            addr_err;

  spi_reg_bank_if bus ();

  spi_reg_bank #(.NUM_REGS(NR), .IDLE_BYTE(IDLE), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  tx_exp_t    tx_q [$];
  wr_exp_t    wr_q [$];
  int         err_q [$];
  logic [7:0] model [NR];

  // Event monitor: every tx_dv / wr_strobe / addr_err must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_dv) begin
        checks++;
        assert (tx_q.size() != 0) else begin
          errors++; $error("FAIL tx_unexpected cyc=%0d byte=%h expected none", cyc, bus.tx_byte);
        end
        if (tx_q.size() != 0) begin
          tx_exp_t e;
          e = tx_q.pop_front();
          checks++;
          assert (cyc === e.cyc && bus.tx_byte === e.data) else begin
            errors++; $error("FAIL tx cyc=%0d byte=%h expected cyc=%0d byte=%h", cyc, bus.tx_byte, e.cyc, e.data);
          end
        end
      end
      if (wr_strobe) begin
        checks++;
        assert (wr_q.size() != 0) else begin
          errors++; $error("FAIL wr_unexpected cyc=%0d addr=%0d expected none", cyc, wr_addr);
        end
        if (wr_q.size() != 0) begin
          wr_exp_t w;
          w = wr_q.pop_front();
          checks++;
          assert (cyc === w.cyc && wr_addr === w.addr && regs[8*w.addr +: 8] === w.data) else begin
            errors++; $error("FAIL wr cyc=%0d addr=%0d reg=%h expected cyc=%0d addr=%0d reg=%h",
                             cyc, wr_addr, regs[8*w.addr +: 8], w.cyc, w.addr, w.data);
          end
        end
      end
      if (addr_err) begin
        checks++;
        assert (err_q.size() != 0) else begin
          errors++; $error("FAIL err_unexpected cyc=%0d expected none", cyc);
        end
        if (err_q.size() != 0) begin
          int c;
          c = err_q.pop_front();
          checks++;
          assert (cyc === c) else begin
            errors++; $error("FAIL err_cycle cyc=%0d expected %0d", cyc, c);
          end
        end
      end
    end
  end

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] v;
    for (int i = 0; i < NR; i++) v[8*i +: 8] = model[i];
    return v;
  endfunction

  task automatic check_regs(input string tag);
    checks++;
    assert (regs === model_flat()) else begin
      errors++; $error("FAIL %s regs=%h expected %h", tag, regs, model_flat());
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic start_frame();
    bus.spi_cs = 1'b0;
    tx_q.push_back('{cyc + 3, IDLE});
    repeat (5) @(negedge clk);
  endtask

  task automatic end_frame();
    bus.spi_cs = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit tx_en, input logic [7:0] tx_val,
                      input bit err, input bit wr, input logic [6:0] wa);
    bus.rx_byte = b;
    bus.rx_dv   = 1'b1;
    if (tx_en) tx_q.push_back('{cyc + 1, tx_val});
    if (err)   err_q.push_back(cyc + 1);
    if (wr) begin
      wr_q.push_back('{cyc + 1, wa, b});
      model[wa] = b;
    end
    @(negedge clk);
    bus.rx_dv = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    reset       = 1'b1;
    bus.spi_cs  = 1'b1;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    repeat (3) @(negedge clk);

    check_regs("reset_regs");
    check_val("reset_tx_byte", bus.tx_byte, IDLE);
    check_val("reset_outs", {5'd0, bus.tx_dv, wr_strobe, addr_err}, 8'h00);
    check_val("reset_wr_addr", {1'b0, wr_addr}, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Seed reg7, then reset in the middle of a read frame.
    start_frame();
    send(8'h87, 1, IDLE, 0, 0, 7'd0);
    send(8'h3C, 1, IDLE, 0, 1, 7'd7);
    end_frame();
    check_regs("seed_reg7");

    start_frame();
    send(8'h07, 1, 8'h3C, 0, 0, 7'd0);
    reset      = 1'b1;
    bus.spi_cs = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    check_regs("midframe_reset_regs");
    check_val("midframe_reset_tx_byte", bus.tx_byte, IDLE);
    check_val("midframe_reset_outs", {5'd0, bus.tx_dv, wr_strobe, addr_err}, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Write reg3.
    start_frame();
    send(8'h83, 1, IDLE, 0, 0, 7'd0);
    send(8'h5C, 1, IDLE, 0, 1, 7'd3);
    end_frame();
    check_regs("write_reg3");

    // Read reg3 back.
    start_frame();
    send(8'h03, 1, 8'h5C, 0, 0, 7'd0);
    send(8'h00, 1, BURST ? model[4] : IDLE, 0, 0, 7'd0);
    end_frame();

    // Out-of-range write and read.
    start_frame();
    send(8'h94, 1, IDLE, 0, 0, 7'd0);
    send(8'hFF, 1, IDLE, 1, 0, 7'd0);
    end_frame();
    check_regs("oor_write_discarded");

    start_frame();
    send(8'h14, 1, 8'h00, 0, 0, 7'd0);
    send(8'h00, 1, BURST ? 8'h00 : IDLE, 1, 0, 7'd0);
    end_frame();

    // Aborted write: frame ends after the command byte.
    start_frame();
    send(8'h85, 1, IDLE, 0, 0, 7'd0);
    end_frame();
    send(8'h22, 0, 8'h00, 0, 0, 7'd0);
    check_regs("aborted_write");

    start_frame();
    send(8'h85, 1, IDLE, 0, 0, 7'd0);
    send(8'h11, 1, IDLE, 0, 1, 7'd5);
    end_frame();
    check_regs("write_reg5");

    if (BURST) begin
      start_frame();
      send(8'h8F, 1, IDLE, 0, 0, 7'd0);
      send(8'h01, 1, IDLE, 0, 1, 7'd15);
      send(8'h02, 1, IDLE, 1, 0, 7'd0);
      end_frame();
      check_regs("burst_write");

      start_frame();
      send(8'h7F, 1, 8'h00, 0, 0, 7'd0);
      send(8'h00, 1, model[0], 1, 0, 7'd0);
      send(8'h00, 1, model[1], 0, 0, 7'd0);
      end_frame();
    end else begin
      start_frame();
      send(8'h8E, 1, IDLE, 0, 0, 7'd0);
      send(8'hAB, 1, IDLE, 0, 1, 7'd14);
      send(8'hCD, 0, 8'h00, 0, 0, 7'd0);
      end_frame();
      check_regs("single_write_ignore");
    end

    repeat (5) @(negedge clk);
    check_val("tx_queue_drained", 8'(tx_q.size()), 8'd0);
    check_val("wr_queue_drained", 8'(wr_q.size()), 8'd0);
    check_val("err_queue_drained", 8'(err_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register-file stage directly downstream of the SPI slave byte interface.
- Consumes received bytes (rx_dv/rx_byte) framed by chip-select and decodes a command/address byte followed by data bytes.
- Returns read data to the slave through tx_dv/tx_byte.
- Exposes the register contents as a flat vector for the rest of the chip (configuration registers driven over SPI).

Parameters:
- NUM_REGS, 16, number of read/write 8-bit registers; legal range 1..128, mapped at addresses 0..NUM_REGS-1.
- IDLE_BYTE, 8'hA5, byte preloaded for transmission during the command byte and after a frame ends.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock; same clock as the SPI slave.
- reset  input  1  asynchronous, active-high reset.
- spi_cs  input  1  raw SPI chip-select, active-low, asynchronous to clk.
- rx_dv  input  1  one-cycle pulse: rx_byte is valid.
- rx_byte  input  8  byte received from the master.
- tx_dv  output  1  one-cycle pulse: load tx_byte into the slave shifter.
- tx_byte  output  8  byte for the slave to transmit next.
- regs  output  NUM_REGS*8  flat register contents; reg n occupies bits [8n+7:8n].
- wr_strobe  output  1  one-cycle pulse on each register write.
- wr_addr  output  7  address written; valid while wr_strobe=1.
- addr_err  output  1  one-cycle pulse on an access to address >= NUM_REGS.

Behaviour:
- Reset (async, active-high):
  - regs all RESET_VAL; tx_byte=IDLE_BYTE.
  - tx_dv, wr_strobe, addr_err = 0; wr_addr=0.
  - State IDLE; CS synchronizer flops = 1 (deasserted).
- spi_cs passes through a 2-flop synchronizer to cs_s. Frame start = cs_s 1->0; frame end = cs_s 0->1. rx_dv is only honoured while cs_s=0.
- Command byte format: bit7 = 1 write / 0 read; bits[6:0] = address.
- State machine:
  - IDLE: on frame start, pulse tx_dv with tx_byte=IDLE_BYTE, then go to CMD.
  - CMD: on rx_dv, latch op and addr, then go to DATA. If the op is read, pulse tx_dv exactly 1 cycle after rx_dv, with tx_byte = reg[addr] (8'h00 if addr >= NUM_REGS). If the op is write, pulse tx_dv with IDLE_BYTE.
  - DATA, write: on rx_dv, reg[addr] <= rx_byte in the same cycle. wr_strobe=1 and wr_addr=addr on the following cycle, when the new value is visible on regs. If addr >= NUM_REGS, the write is discarded, no wr_strobe, and addr_err pulses.
  - DATA, read: on rx_dv (the byte is a dummy), the current read completes. addr_err pulses if addr >= NUM_REGS.
  - After each DATA byte, next state and next tx preload are set per the optional feature.
  - IGNORE: rx_dv is ignored and tx is not reloaded.
  - Any state: frame end forces IDLE next cycle, discarding any partial command; regs are unchanged. Frame end takes priority over a coincident rx_dv.
- Read data is sampled at the tx_dv cycle. A write to the same address in the same frame is impossible by protocol.
- Latency:
  - rx_dv -> tx_dv: 1 cycle.
  - rx_dv -> wr_strobe: 1 cycle.
  - Frame start (spi_cs fall) -> tx_dv: 3 cycles.
- Address arithmetic is 7-bit modulo 128 (127 wraps to 0).

Optional Feature:
- Macro SPI_REGBANK_BURST_EN.
- Defined: DATA stays in DATA and addr increments (mod 128) after every data byte.
  - Write burst: each subsequent byte writes the next address.
  - Read burst: tx_dv 1 cycle after each rx_dv, with reg[addr+1] (8'h00 if out of range).
- Not defined: after the first data byte, go to IGNORE and preload tx_byte=IDLE_BYTE via tx_dv; further bytes in the frame have no effect.

Test Plan:
- Reset mid-frame (during CMD) -> all regs 8'h00, tx_byte=8'hA5, outputs 0, IDLE. Next frame start -> tx_dv with 8'hA5 after 3 cycles.
- Write frame 8'h83, 8'h5C -> reg[3]=8'h5C; wr_strobe pulse with wr_addr=3; no other reg changes.
- Read frame 8'h03, 8'h00 after the prior write -> tx_dv 1 cycle after command rx_dv with tx_byte=8'h5C; master receives 8'hA5 then 8'h5C.
- Out of range (NUM_REGS=16): write 8'h94, 8'hFF -> addr_err pulse, no wr_strobe, regs unchanged. Read 8'h14 -> tx_byte 8'h00 and addr_err pulse.
- spi_cs rises after the command byte 8'h85, before data -> IDLE, reg[5] unchanged. Next frame 8'h85, 8'h11 writes reg[5]=8'h11.
- Burst:
  - BURST_EN: 8'h8F, 8'h01, 8'h02 with NUM_REGS=16 -> reg15=8'h01, then addr_err for addr 16.
  - BURST_EN read 8'h7F, x, x -> tx 8'h00, 8'h00 (addr 0 after wrap 127->0 returns reg0=8'h00).
  - Without BURST_EN: 8'h8E, 8'hAB, 8'hCD -> reg14=8'hAB, reg15 unchanged.
